// File: rtl/sw_chain_pkg.sv
// ---------------------------------------------------------------------------
// sw_chain_pkg
// Shared constants and helpers for the switch-to-LED evaluation chain.
//   LUT_AND4 / LUT_OR4 : ready-made 4-input truth tables, indexed {D,C,B,A}
//   MAX_STAGES         : largest chain the LUT helper can address
//   sw_width(n)        : switch bus width needed by an n-stage chain
//   lut_bit(luts,k,i)  : bit i of stage k's truth table within a packed bus
// ---------------------------------------------------------------------------
package sw_chain_pkg;

  localparam logic [15:0] LUT_AND4 = 16'h8000;
  localparam logic [15:0] LUT_OR4  = 16'hFFFE;

  // Stage index is carried as 6 bits, so the padded LUT bus is 64 tables wide.
  localparam int MAX_STAGES = 64;
  localparam int LUT_BUS_W  = 16 * MAX_STAGES;

  // Stage 0 eats four switches, every later stage adds three fresh ones.
  function automatic int sw_width(input int n);
    return 3 * n + 1;
  endfunction

  // {k, idx} is exactly 16*k + idx, which keeps the select index the same
  // width as the bus.
  function automatic logic lut_bit(input logic [LUT_BUS_W-1:0] luts,
                                   input logic [5:0]           k,
                                   input logic [3:0]           idx);
    return luts[{k, idx}];
  endfunction

endpackage

// File: rtl/sw_chain_eval_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// One switch bit: two-flop synchroniser followed (when DEBOUNCE_EN is
// defined) by a counter-based debouncer.
//   clk, rst : clock and synchronous active-high reset
//   sw_in    : raw asynchronous switch level
//   db_out   : clean level seen by the logic chain
//   db_chg   : high in the cycle before an edge that will change db_out
// Configuration macro: DEBOUNCE_EN. Without it db_out is simply the second
// synchroniser flop and no counter exists.
// ---------------------------------------------------------------------------
module sw_debounce
`ifdef DEBOUNCE_EN
#(
  parameter int DB_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic db_out,
  output logic db_chg
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Synchroniser next-state: plain two-deep shift of the raw switch.
  always_comb begin
    s1_d = sw_in;
    s2_d = s1_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; the last one of the run takes
  // the new level. Any agreeing cycle throws the partial count away, so
  // short glitches never get through.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounced level and run counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_out = db_q;
  assign db_chg = (db_d != db_q);
`else
  assign db_out = s2_q;
  assign db_chg = (s2_d != s2_q);
`endif

endmodule

// File: rtl/sw_chain_eval.sv
// ---------------------------------------------------------------------------
// sw_chain_eval
// Clocked chain of N_STAGES programmable 4-input functions driven by
// synchronised (optionally debounced) switches. Fresh switch inputs of later
// stages are delayed so every LED reflects one switch snapshot.
//   clk     : system clock
//   rst     : synchronous active-high reset, clears all state
//   sw      : asynchronous switch inputs, 3*N_STAGES+1 bits
//   led     : led[k] is the registered output of stage k
//   settled : high once led reflects the current debounced switches
// Configuration macro: DEBOUNCE_EN (see sw_debounce).
// ---------------------------------------------------------------------------
module sw_chain_eval
  import sw_chain_pkg::*;
#(
  parameter int                      N_STAGES   = 2,
  parameter int                      DB_CYCLES  = 4,
  parameter logic [16*N_STAGES-1:0]  STAGE_LUTS = {LUT_OR4, LUT_AND4}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [sw_width(N_STAGES)-1:0]     sw,
  output logic [N_STAGES-1:0]               led,
  output logic                              settled
);

  localparam int SW_W = sw_width(N_STAGES);
  localparam int QW   = $clog2(N_STAGES + 1);
  localparam logic [LUT_BUS_W-1:0] LUTS_EXT = LUT_BUS_W'(STAGE_LUTS);

  // Reject configurations the LUT addressing or debouncer cannot honour.
  if (N_STAGES < 1 || N_STAGES > MAX_STAGES || DB_CYCLES < 1) begin : g_bad_cfg
    $error("sw_chain_eval: unsupported N_STAGES/DB_CYCLES");
  end

  logic [SW_W-1:0] db;
  logic [SW_W-1:0] db_chg;

  for (genvar i = 0; i < SW_W; i++) begin : g_db
    sw_debounce
`ifdef DEBOUNCE_EN
      #(.DB_CYCLES(DB_CYCLES))
`endif
      u_debounce (
        .clk   (clk),
        .rst   (rst),
        .sw_in (sw[i]),
        .db_out(db[i]),
        .db_chg(db_chg[i])
      );
  end

  logic [N_STAGES-1:0] stage_q, stage_d;
  logic [3:0]          stage_idx [N_STAGES];

  assign stage_idx[0] = db[3:0];

  // Stage k sees its B/C/D switches k cycles late, matching the k cycles its
  // A input needs to ripple down from stage 0.
  for (genvar k = 1; k < N_STAGES; k++) begin : g_align
    logic [2:0] dly_q [k];
    logic [2:0] dly_d [k];

    // Shift the three fresh switches of this stage down the delay line.
    always_comb begin
      dly_d[0] = db[3*k+1 +: 3];
      for (int j = 1; j < k; j++) begin
        dly_d[j] = dly_q[j-1];
      end
    end

    // Delay line registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < k; j++) begin
          dly_q[j] <= '0;
        end
      end else begin
        dly_q <= dly_d;
      end
    end

    assign stage_idx[k] = {dly_q[k-1], stage_q[k-1]};
  end

  // Look every stage up in its own truth table.
  always_comb begin
    stage_d = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      stage_d[k] = lut_bit(LUTS_EXT, 6'(k), stage_idx[k]);
    end
  end

  // Stage registers drive the LEDs directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  logic [QW-1:0] quiet_q, quiet_d;

  // Cycles since the last debounced change; once it reaches the chain depth
  // the new snapshot has reached the last stage. Several bits changing on
  // the same edge count as one event.
  always_comb begin
    quiet_d = quiet_q;
    if (|db_chg) begin
      quiet_d = '0;
    end else if (quiet_q != QW'(N_STAGES)) begin
      quiet_d = quiet_q + QW'(1);
    end
  end

  // Quiet counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      quiet_q <= '0;
    end else begin
      quiet_q <= quiet_d;
    end
  end

  assign led     = stage_q;
  assign settled = (quiet_q == QW'(N_STAGES));

endmodule

// File: tb/tb_sw_chain_eval.sv
// ---------------------------------------------------------------------------
// tb_sw_chain_eval
// Directed scoreboard bench for sw_chain_eval (default parameters: two
// stages, AND4 then OR4, DB_CYCLES = 4). The driver pushes the expected
// {led, settled} for every edge it drives; a separate monitor pops and
// compares one entry after each edge. Timings follow DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_sw_chain_eval;

  localparam int SW_W = 7;
`ifdef DEBOUNCE_EN
  localparam int DBL = 4;
`else
  localparam int DBL = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SW_W-1:0] sw  = '0;
  logic [1:0]      led;
  logic            settled;

  always #5 clk = ~clk;

  sw_chain_eval dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .led    (led),
    .settled(settled)
  );

  typedef struct packed {
    logic [7:0] test_id;
    logic [7:0] cyc;
    logic [1:0] led;
    logic       settled;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   test_id = 0;
  int   cyc     = 0;

  // Drive one edge worth of inputs and queue what must be seen after it.
  task automatic applyStimulus(input logic [SW_W-1:0] sw_val, input logic rst_val,
                               input logic [1:0] exp_led, input logic exp_settled);
    exp_t e;
    @(negedge clk);
    sw  = sw_val;
    rst = rst_val;
    cyc++;
    e.test_id = 8'(test_id);
    e.cyc     = 8'(cyc);
    e.led     = exp_led;
    e.settled = exp_settled;
    exp_q.push_back(e);
  endtask

  // Compare the DUT against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    total++;
    if (led !== e.led || settled !== e.settled) begin
      bad++;
      $display("[TB] FAIL t%0d_c%0d led/settled: got %b/%b expected %b/%b",
               e.test_id, e.cyc, led, settled, e.led, e.settled);
    end
  endtask

  // Start a new directed test; edge numbering restarts at 1.
  task automatic newTest();
    test_id++;
    cyc = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 2'b00, 1'b1);
  endtask

  // Hold sw_val from a settled state. db moves at edge 2+DBL, led[0] at
  // 3+DBL, led[1] at 4+DBL; settled is low from 2+DBL through 3+DBL.
  task automatic holdTest(input logic [SW_W-1:0] sw_val, input logic [1:0] old_led,
                          input logic [1:0] new_led, input bit db_changes);
    int n_cyc = 7 + DBL;
    newTest();
    for (int n = 1; n <= n_cyc; n++) begin
      logic [1:0] el;
      logic       es;
      el[0] = (n >= 3 + DBL) ? new_led[0] : old_led[0];
      el[1] = (n >= 4 + DBL) ? new_led[1] : old_led[1];
      es    = !db_changes || (n < 2 + DBL) || (n >= 4 + DBL);
      applyStimulus(sw_val, 1'b0, el, es);
    end
  endtask

  // Monitor: one comparison after every edge that has an expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int R;
    // Reset for two edges, then release: settled from the 2nd edge after.
    newTest();
    applyStimulus('0, 1'b1, 2'b00, 1'b0);
    applyStimulus('0, 1'b1, 2'b00, 1'b0);
    applyStimulus('0, 1'b0, 2'b00, 1'b0);
    idle(5);

    // AND stage fires, OR stage follows one edge later.
    holdTest(7'b0001111, 2'b00, 2'b11, 1'b1);
    holdTest(7'b0000000, 2'b11, 2'b00, 1'b1);
    // D input of the OR stage alone.
    holdTest(7'b1000000, 2'b00, 2'b10, 1'b1);
    holdTest(7'b0000000, 2'b10, 2'b00, 1'b1);
    // Three of four AND inputs: db changes, LEDs stay dark.
    holdTest(7'b0001110, 2'b00, 2'b00, 1'b1);

    // Glitch on sw[0] while the other AND inputs are high.
    newTest();
`ifdef DEBOUNCE_EN
    for (int i = 0; i < 3; i++) applyStimulus(7'b0001111, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(7'b0001110, 1'b0, 2'b00, 1'b1);
`else
    applyStimulus(7'b0001111, 1'b0, 2'b00, 1'b1);
    applyStimulus(7'b0001110, 1'b0, 2'b00, 1'b0);
    applyStimulus(7'b0001110, 1'b0, 2'b01, 1'b0);
    applyStimulus(7'b0001110, 1'b0, 2'b10, 1'b0);
    applyStimulus(7'b0001110, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(7'b0001110, 1'b0, 2'b00, 1'b1);
`endif
    holdTest(7'b0000000, 2'b00, 2'b00, 1'b1);

    // Reset in the middle of an input change discards it.
    newTest();
    R = 2 + DBL / 2;
    for (int n = 1; n < R; n++) applyStimulus(7'b0001111, 1'b0, 2'b00, 1'b1);
    applyStimulus('0, 1'b1, 2'b00, 1'b0);
    applyStimulus('0, 1'b0, 2'b00, 1'b0);
    idle(10);

    // Reset with both LEDs lit clears them on the reset edge.
    holdTest(7'b0001111, 2'b00, 2'b11, 1'b1);
    newTest();
    applyStimulus('0, 1'b1, 2'b00, 1'b0);
    applyStimulus('0, 1'b0, 2'b00, 1'b0);
    idle(8);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
